// File: rtl/lcd_spi_rx_if.sv
// lcd_spi_rx_if: SPI-side LCD pins plus pixel stream handshake.
// Optional byte monitor signals exist when LCD_SPI_RX_BYTE_PORT_EN is defined.
interface lcd_spi_rx_if #(
    parameter int W_COORD = 9
);
    logic               lcd_cs;
    logic               lcd_dc;
    logic               lcd_sck;
    logic               lcd_mosi;
    logic               pix_valid;
    logic               pix_ready;
    logic [W_COORD-1:0] pix_x;
    logic [W_COORD-1:0] pix_y;
    logic [15:0]        pix_data;
    logic               ovf;
    logic               ovf_clr;
`ifdef LCD_SPI_RX_BYTE_PORT_EN
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_dc;
`endif

    modport master (
`ifdef LCD_SPI_RX_BYTE_PORT_EN
        input  byte_valid, byte_data, byte_dc,
`endif
        output lcd_cs, lcd_dc, lcd_sck, lcd_mosi,
        output pix_ready, ovf_clr,
        input  pix_valid, pix_x, pix_y, pix_data, ovf
    );

    modport slave (
`ifdef LCD_SPI_RX_BYTE_PORT_EN
        output byte_valid, byte_data, byte_dc,
`endif
        input  lcd_cs, lcd_dc, lcd_sck, lcd_mosi,
        input  pix_ready, ovf_clr,
        output pix_valid, pix_x, pix_y, pix_data, ovf
    );
endinterface

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: SPI LCD controller receiver (CASET/RASET/RAMWR) -> pixel stream.
// Define LCD_SPI_RX_BYTE_PORT_EN to expose every received byte on the bus.
module lcd_spi_rx #(
    parameter int W_COORD = 9
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    lcd_spi_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, CASET, RASET, RAMWR_HI, RAMWR_LO, IGNORE
    } state_t;

    logic [1:0] r_cs_sync;
    logic [1:0] r_dc_sync;
    logic [1:0] r_sck_sync;
    logic [1:0] r_mosi_sync;
    logic       r_sck_prev;

    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_byte_done;
    logic       r_byte_dc;

    state_t             r_state;
    logic [1:0]         r_pcnt;
    logic [7:0]         r_p0;
    logic [7:0]         r_p1;
    logic [7:0]         r_p2;
    logic [7:0]         r_hi;
    logic [W_COORD-1:0] r_x;
    logic [W_COORD-1:0] r_y;
    logic [W_COORD-1:0] r_x_start;
    logic [W_COORD-1:0] r_x_end;
    logic [W_COORD-1:0] r_y_start;
    logic [W_COORD-1:0] r_y_end;
    logic               r_pix_valid;
    logic [W_COORD-1:0] r_pix_x;
    logic [W_COORD-1:0] r_pix_y;
    logic [15:0]        r_pix_data;
    logic               r_ovf;

    logic               w_cs;
    logic               w_sck_rise;
    logic               w_acc;
    logic [W_COORD-1:0] w_start;
    logic [W_COORD-1:0] w_end;

    assign w_cs       = r_cs_sync[1];
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev & ~w_cs;
    assign w_acc      = r_pix_valid & bus.pix_ready;
    assign w_start    = W_COORD'({r_p0, r_p1});
    assign w_end      = W_COORD'({r_p2, r_shift});

    // Two-flop synchronisers plus sck history for edge detection
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= '0;
            r_dc_sync   <= '0;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], bus.lcd_cs};
            r_dc_sync   <= {r_dc_sync[0], bus.lcd_dc};
            r_sck_sync  <= {r_sck_sync[0], bus.lcd_sck};
            r_mosi_sync <= {r_mosi_sync[0], bus.lcd_mosi};
            r_sck_prev  <= r_sck_sync[1];
        end
    end

    // Bit assembly; a raised cs throws away any partial byte
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_byte_done <= 1'b0;
            r_byte_dc   <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_cs) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_sck_rise) begin
                r_shift  <= {r_shift[6:0], r_mosi_sync[1]};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_byte_done <= 1'b1;
                    r_byte_dc   <= r_dc_sync[1];
                end
            end
        end
    end

    // Command decoder, window registers and pixel output stage
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pcnt      <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_hi        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_x_start   <= '0;
            r_y_start   <= '0;
            r_x_end     <= '1;
            r_y_end     <= '1;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_data  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_acc) r_pix_valid <= 1'b0;
            if (bus.ovf_clr) r_ovf <= 1'b0;
            if (r_byte_done && !r_byte_dc) begin
                r_pcnt <= '0;
                unique case (r_shift)
                    8'h2A: r_state <= CASET;
                    8'h2B: r_state <= RASET;
                    8'h2C: begin
                        r_state <= RAMWR_HI;
                        r_x     <= r_x_start;
                        r_y     <= r_y_start;
                    end
                    default: r_state <= IGNORE;
                endcase
            end else if (r_byte_done) begin
                unique case (r_state)
                    CASET, RASET: begin
                        r_pcnt <= r_pcnt + 2'd1;
                        unique case (r_pcnt)
                            2'd0: r_p0 <= r_shift;
                            2'd1: r_p1 <= r_shift;
                            2'd2: r_p2 <= r_shift;
                            default: begin
                                r_state <= IGNORE;
                                if (r_state == CASET) begin
                                    r_x_start <= w_start;
                                    r_x_end   <= w_end;
                                end else begin
                                    r_y_start <= w_start;
                                    r_y_end   <= w_end;
                                end
                            end
                        endcase
                    end
                    RAMWR_HI: begin
                        r_hi    <= r_shift;
                        r_state <= RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        r_state <= RAMWR_HI;
                        if (!r_pix_valid || w_acc) begin
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_data  <= {r_hi, r_shift};
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        if (r_x == r_x_end) begin
                            r_x <= r_x_start;
                            if (r_y == r_y_end) r_y <= r_y_start;
                            else r_y <= r_y + W_COORD'(1);
                        end else begin
                            r_x <= r_x + W_COORD'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_x     = r_pix_x;
    assign bus.pix_y     = r_pix_y;
    assign bus.pix_data  = r_pix_data;
    assign bus.ovf       = r_ovf;

`ifdef LCD_SPI_RX_BYTE_PORT_EN
    assign bus.byte_valid = r_byte_done;
    assign bus.byte_data  = r_shift;
    assign bus.byte_dc    = r_byte_dc;
`endif

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter W_COORD, default 9, width of pixel coordinate outputs and window registers.
REQ-002 SHALL have ports clk_sys  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports lcd_cs  in  1  chip select, active-low; lcd_dc  in  1  0=command 1=data; lcd_sck  in  1  SPI clock, mode 0; lcd_mosi  in  1  serial data, MSB first.
REQ-004 SHALL have ports pix_valid  out  1; pix_ready  in  1; pix_x  out  W_COORD; pix_y  out  W_COORD; pix_data  out  16  RGB565.
REQ-005 SHALL have ports ovf  out  1  sticky pixel-drop flag; ovf_clr  in  1  clears ovf.

Function
REQ-006 SHALL pass lcd_cs, lcd_dc, lcd_sck, lcd_mosi through 2-flop synchronisers to clk_sys; all decoding uses synchronised values.
REQ-007 SHALL support lcd_sck high and low phases each >= 3 clk_sys cycles; faster sck is out of spec.
REQ-008 SHALL, on each synchronised sck rising edge while cs low, shift mosi into an 8-bit shifter and increment a 3-bit bit counter.
REQ-009 SHALL, on the 8th such edge, complete a byte tagged with dc sampled at that same edge, and return the bit counter to 0.
REQ-010 SHALL, while synchronised cs is high, hold the bit counter at 0, discard any partial byte, and leave decoder state unchanged.
REQ-011 SHALL run a decoder FSM with states IDLE, CASET, RASET, RAMWR_HI, RAMWR_LO, IGNORE, advanced once per completed byte.
REQ-012 SHALL, on any command byte (dc=0) in any state: 0x2A -> CASET, 0x2B -> RASET, 0x2C -> RAMWR_HI with x=x_start y=y_start, other -> IGNORE; param count reset to 0.
REQ-013 SHALL, in CASET/RASET, collect 4 data bytes (start_hi, start_lo, end_hi, end_lo), truncate each 16-bit value to W_COORD LSBs, and update start/end registers only on the 4th byte, then enter IGNORE.
REQ-014 SHALL discard partial CASET/RASET parameters when a command byte arrives before the 4th.
REQ-015 SHALL ignore data bytes in IDLE and IGNORE.
REQ-016 SHALL, in RAMWR_HI, latch the data byte as pixel[15:8] and go to RAMWR_LO; in RAMWR_LO, form the pixel with byte as [7:0], emit it at (x,y), return to RAMWR_HI.
REQ-017 SHALL advance after each emitted pixel: x==x_end -> x=x_start and (y==y_end -> y=y_start, else y+1); else x+1; all W_COORD-bit wrap.
REQ-018 SHALL assert pix_valid the cycle after the clk_sys edge completing the low byte, holding pix_x/pix_y/pix_data stable until pix_valid && pix_ready.
REQ-019 SHALL, if a pixel completes while pix_valid && !pix_ready, drop the new pixel, keep the pending one, still advance x/y, and set ovf.
REQ-020 SHALL, if a pixel completes in the same cycle the pending pixel is accepted, load the new pixel with no overflow.
REQ-021 SHALL clear ovf when ovf_clr is high; a set and clear in the same cycle leaves ovf set.
REQ-022 SHALL discard an unpaired high byte when a command byte arrives in RAMWR_LO.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear synchronisers, shifter, bit counter, ovf, pix_valid, pix_x, pix_y, pix_data, x, y, x_start, y_start to 0, set x_end and y_end to all-ones, and set FSM to IDLE.
REQ-024 SHALL, on reset mid-byte or mid-pixel, discard the partial byte/pixel; first byte after release is decoded from bit 0.

Configuration
REQ-025 SHALL, with LCD_SPI_RX_BYTE_PORT_EN defined, add ports byte_valid out 1, byte_data out 8, byte_dc out 1, pulsing byte_valid for one cycle per completed byte (REQ-009) regardless of FSM state, reset to 0.
REQ-026 SHALL, without LCD_SPI_RX_BYTE_PORT_EN, omit those ports and their logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: CASET 00 02 00 03, RASET 00 05 00 06, RAMWR, 5 pixels 0x1234..0x1238, pix_ready=1 -> (2,5)(3,5)(2,6)(3,6)(2,5) with matching data, ovf=0.
REQ-028 SHALL cover: RAMWR with pix_ready=0, 2 pixels 0xAAAA, 0xBBBB -> pix_data stays 0xAAAA at (0,0), ovf=1; then pix_ready=1, ovf_clr=1 -> accepted, ovf=0.
REQ-029 SHALL cover: 5 bits clocked, cs raised, then cs lowered and 0x2A plus 4 params sent -> partial byte discarded, CASET applied.
REQ-030 SHALL cover: CASET 00 01 (2 params) then 0x2C and pixel 0xF800 -> window unchanged, pixel at (0,0).
REQ-031 SHALL cover: 0x3A command followed by data 0x55 0x66 -> no pix_valid, no register change; with LCD_SPI_RX_BYTE_PORT_EN, 3 byte_valid pulses with dc 0,1,1.
REQ-032 SHALL cover: rst_n asserted after RAMWR high byte -> after release, pixel pair without new RAMWR produces no pix_valid.
